// File: rtl/video_scanout.sv
// video_scanout: snapshots a grid of per-cell video values and streams them out in raster order.
// Ports: clk, rst (async active-low), video_bus (cell (x,y) at (y*GRID_W+x)*VALUE_W),
//        frame_req; pix_ready in, pix_valid/pix_data/pix_x/pix_y/pix_last out (valid/ready stream);
//        busy, frame_done; dropped_cnt only when VIDEO_SCANOUT_DROP_CNT_EN is defined.
module video_scanout #(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int VALUE_W = 16,
  localparam int XW = GRID_W > 1 ? $clog2(GRID_W) : 1,
  localparam int YW = GRID_H > 1 ? $clog2(GRID_H) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [GRID_W*GRID_H*VALUE_W-1:0] video_bus,
  input  logic                        frame_req,
  input  logic                        pix_ready,
  output logic                        pix_valid,
  output logic [VALUE_W-1:0]          pix_data,
  output logic [XW-1:0]               pix_x,
  output logic [YW-1:0]               pix_y,
  output logic                        pix_last,
  output logic                        busy,
  output logic                        frame_done
`ifdef VIDEO_SCANOUT_DROP_CNT_EN
  ,
  output logic [7:0]                  dropped_cnt
`endif
);
  localparam int N = GRID_W * GRID_H;
  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state_q;
  logic [VALUE_W-1:0] snap_q [N];
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic valid_q, last_q, done_q;
  logic [VALUE_W-1:0] data_q;
  // raster successor of the current coordinate
  always_comb begin
    x_d = (x_q == XMAX) ? '0 : x_q + 1'b1;
    y_d = (x_q == XMAX) ? y_q + 1'b1 : y_q;
  end
  // snapshot has no reset: its contents are only ever read after a capture
  always_ff @(posedge clk) begin
    if (state_q == IDLE && frame_req)
      for (int i = 0; i < N; i++) snap_q[i] <= video_bus[i*VALUE_W +: VALUE_W];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (frame_req) begin
          state_q <= STREAM;
          x_q     <= '0;
          y_q     <= '0;
          valid_q <= 1'b0 | 1'b1;
          data_q  <= video_bus[VALUE_W-1:0];
          last_q  <= (N == 1);
        end
        STREAM: if (pix_ready) begin
          if (last_q) begin
            state_q <= DONE;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            data_q <= snap_q[int'(y_d) * GRID_W + int'(x_d)];
            last_q <= (x_d == XMAX) && (y_d == YMAX);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef VIDEO_SCANOUT_DROP_CNT_EN
  // any request outside IDLE (including the frame_done cycle) is dropped; saturates at 255
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dropped_cnt <= '0;
    else if (frame_req && state_q != IDLE && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
  end
`endif
  assign pix_valid  = valid_q;
  assign pix_data   = data_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_last   = last_q;
  assign busy       = state_q != IDLE;
  assign frame_done = done_q;
endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout: directed checks of the 2x2 scan-out stream, stalls, snapshot isolation, drops and reset.
module tb_video_scanout;
  logic clk = 1'b0, rst = 1'b0, frame_req = 1'b0, pix_ready = 1'b1;
  logic [63:0] video_bus;
  logic pix_valid, pix_last, busy, frame_done;
  logic [15:0] pix_data;
  logic pix_x, pix_y;
  int checks = 0, failures = 0;
`ifdef VIDEO_SCANOUT_DROP_CNT_EN
  logic [7:0] dropped_cnt;
`endif
  video_scanout #(.GRID_W(2), .GRID_H(2), .VALUE_W(16)) dut (
    .clk(clk), .rst(rst), .video_bus(video_bus), .frame_req(frame_req), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
`ifdef VIDEO_SCANOUT_DROP_CNT_EN
    , .dropped_cnt(dropped_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input string tag, input logic [15:0] d, input logic x, input logic y, input logic l);
    chk({tag, "_valid"}, 32'(pix_valid), 1);
    chk({tag, "_data"}, 32'(pix_data), 32'(d));
    chk({tag, "_xy"}, {30'd0, pix_y, pix_x}, {30'd0, y, x});
    chk({tag, "_last"}, 32'(pix_last), 32'(l));
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask
  task automatic idle_chk(input string tag, input logic done);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_done"}, 32'(frame_done), 32'(done));
  endtask
  initial begin
    video_bus = {16'd4, 16'd3, 16'd2, 16'd1};
    #12;
    idle_chk("reset", 1'b0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_data", 32'(pix_data), 0);
    chk("reset_last", 32'(pix_last), 0);
`ifdef VIDEO_SCANOUT_DROP_CNT_EN
    chk("reset_drop", 32'(dropped_cnt), 0);
`endif
    rst = 1'b1;
    tick;
    // full-rate frame; the bus is overwritten after capture and must not leak through
    frame_req = 1'b1;
    tick;
    frame_req = 1'b0;
    beat("f1b1", 16'd1, 1'b0, 1'b0, 1'b0);
    video_bus = {4{16'hFFFF}};
    tick; beat("f1b2", 16'd2, 1'b1, 1'b0, 1'b0);
    tick; beat("f1b3", 16'd3, 1'b0, 1'b1, 1'b0);
    tick; beat("f1b4", 16'd4, 1'b1, 1'b1, 1'b1);
    tick; idle_chk("f1done", 1'b1);
    chk("f1done_busy", 32'(busy), 1);
    tick; idle_chk("f1idle", 1'b0);
    chk("f1idle_busy", 32'(busy), 0);
    // stalled frame with a dropped request during the stall
    video_bus = {16'd8, 16'd7, 16'd6, 16'd5};
    frame_req = 1'b1;
    tick;
    frame_req = 1'b0;
    beat("f2b1", 16'd5, 1'b0, 1'b0, 1'b0);
    tick; beat("f2b2", 16'd6, 1'b1, 1'b0, 1'b0);
    pix_ready = 1'b0;
    video_bus = {16'd9, 16'd9, 16'd9, 16'd9};
    frame_req = 1'b1;
    tick; frame_req = 1'b0; beat("stall1", 16'd6, 1'b1, 1'b0, 1'b0);
    tick; beat("stall2", 16'd6, 1'b1, 1'b0, 1'b0);
    tick; beat("stall3", 16'd6, 1'b1, 1'b0, 1'b0);
    pix_ready = 1'b1;
    tick; beat("f2b3", 16'd7, 1'b0, 1'b1, 1'b0);
    tick; beat("f2b4", 16'd8, 1'b1, 1'b1, 1'b1);
    tick; idle_chk("f2done", 1'b1);
    // request coincident with frame_done is dropped
    frame_req = 1'b1;
    tick;
    frame_req = 1'b0;
    idle_chk("coinc", 1'b0);
    chk("coinc_busy", 32'(busy), 0);
`ifdef VIDEO_SCANOUT_DROP_CNT_EN
    chk("coinc_drop", 32'(dropped_cnt), 2);
`endif
    tick;
    chk("coinc_busy2", 32'(busy), 0);
    // 300 requests while stalled: snapshot kept, counter saturates
    video_bus = {16'd4, 16'd3, 16'd2, 16'd1};
    pix_ready = 1'b0;
    frame_req = 1'b1;
    tick;
    video_bus = {4{16'hFFFF}};
    for (int i = 0; i < 300; i++) begin
      frame_req = 1'b1;
      tick;
      frame_req = 1'b0;
      tick;
    end
    beat("sat_hold", 16'd1, 1'b0, 1'b0, 1'b0);
`ifdef VIDEO_SCANOUT_DROP_CNT_EN
    chk("sat_drop", 32'(dropped_cnt), 255);
`endif
    pix_ready = 1'b1;
    tick; beat("sat_b2", 16'd2, 1'b1, 1'b0, 1'b0);
    tick; beat("sat_b3", 16'd3, 1'b0, 1'b1, 1'b0);
    // asynchronous reset mid-frame at beat 3
    #2 rst = 1'b0;
    #1;
    idle_chk("arst", 1'b0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_data", 32'(pix_data), 0);
`ifdef VIDEO_SCANOUT_DROP_CNT_EN
    chk("arst_drop", 32'(dropped_cnt), 0);
`endif
    #1 rst = 1'b1;
    video_bus = {16'hD, 16'hC, 16'hB, 16'hA};
    tick;
    idle_chk("post_rst", 1'b0);
    chk("post_rst_busy", 32'(busy), 0);
    frame_req = 1'b1;
    tick;
    frame_req = 1'b0;
    beat("f3b1", 16'hA, 1'b0, 1'b0, 1'b0);
    tick; beat("f3b2", 16'hB, 1'b1, 1'b0, 1'b0);
    tick; beat("f3b3", 16'hC, 1'b0, 1'b1, 1'b0);
    tick; beat("f3b4", 16'hD, 1'b1, 1'b1, 1'b1);
    tick; idle_chk("f3done", 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/video_scanout.md
VIDEO_SCANOUT -- requirements
Module: video_scanout

Interface
REQ-001 Parameters SHALL be: GRID_W, 8, cell columns; GRID_H, 8, cell rows; VALUE_W, 16, width of one cell video value.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 video_bus  input  GRID_W*GRID_H*VALUE_W  per-cell video outputs; cell (x,y) at bit offset (y*GRID_W+x)*VALUE_W.
REQ-005 frame_req  input  1  one-cycle request to snapshot and stream a frame.
REQ-006 pix_ready  input  1  downstream accepts pixel.
REQ-007 pix_valid  output  1  pixel beat valid.
REQ-008 pix_data  output  VALUE_W  pixel value.
REQ-009 pix_x / pix_y  output  $clog2(GRID_W) / $clog2(GRID_H)  pixel coordinate.
REQ-010 pix_last  output  1  high on the final beat of a frame (x=GRID_W-1, y=GRID_H-1).
REQ-011 busy  output  1  snapshot held, frame not yet fully accepted.
REQ-012 frame_done  output  1  one-cycle pulse after the last beat is accepted.
REQ-013 dropped_cnt  output  8  frames rejected while busy (present only with the configuration macro).

Function
REQ-014 FSM states SHALL be IDLE, STREAM, DONE.
REQ-015 IDLE + frame_req=1: on that clock edge the whole video_bus SHALL be copied into an internal snapshot, x=y=0, next state STREAM.
REQ-016 STREAM: pix_valid=1; pix_data/pix_x/pix_y SHALL reflect the snapshot cell at the current (x,y); first beat valid exactly one cycle after frame_req.
REQ-017 A beat SHALL be accepted when pix_valid & pix_ready; pix_data, pix_x, pix_y SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-018 Scan order SHALL be raster: x increments; at x=GRID_W-1, x wraps to 0 and y increments.
REQ-019 Acceptance of the beat with pix_last=1 SHALL move to DONE; DONE SHALL assert frame_done for exactly one cycle and return to IDLE the following cycle.
REQ-020 busy SHALL be 1 in STREAM and DONE, 0 in IDLE.
REQ-021 frame_req in STREAM or DONE SHALL be ignored (snapshot unchanged) and counted per REQ-027.
REQ-022 frame_req in the same cycle frame_done is high SHALL be ignored; a new request is honoured only in IDLE.
REQ-023 Changes on video_bus after capture SHALL NOT affect streamed pixels.
REQ-024 Throughput with pix_ready held high SHALL be one pixel per cycle; a frame occupies GRID_W*GRID_H+1 cycles from capture to frame_done.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, x=y=0, pix_valid=0, pix_last=0, busy=0, frame_done=0, pix_data=0, dropped_cnt=0; snapshot contents need not be cleared.
REQ-026 Reset mid-frame SHALL abandon the frame with no frame_done; first frame_req after release starts a fresh capture.

Configuration
REQ-027 Macro VIDEO_SCANOUT_DROP_CNT_EN defined: dropped_cnt port exists, increments by 1 per ignored frame_req (REQ-021/022), saturates at 255, never wraps.
REQ-028 Macro undefined: dropped_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 GRID 2x2, VALUE_W 16, bus={4,3,2,1} (cell0=1), frame_req, pix_ready=1 -> beats 1,2,3,4 on cycles 1-4, coords (0,0),(1,0),(0,1),(1,1), pix_last on beat 4, frame_done cycle 5.
REQ-030 Same frame, pix_ready=0 for 3 cycles on beat 2 -> pix_data=2, pix_x=1, pix_y=0 held stable; sequence resumes unchanged.
REQ-031 Capture, then overwrite video_bus with all 0xFFFF during streaming -> streamed values remain 1,2,3,4.
REQ-032 With VIDEO_SCANOUT_DROP_CNT_EN: 300 frame_req pulses while busy (pix_ready=0) -> dropped_cnt=255, snapshot unchanged.
REQ-033 rst=0 asynchronously at beat 3 -> pix_valid, busy 0 immediately, no frame_done; next frame_req streams newly captured bus from (0,0).
REQ-034 frame_req coincident with frame_done -> ignored, busy 0 next cycle, dropped_cnt +1 when enabled.
